param_mod_counter: RTL and testbench
====================================

Name: param_mod_counter

Overview:
Parametrised modulo up/down counter, the next generation of the fixed-width 16/32 adder counters. It adds a configurable width, modulus and step, a runtime direction, synchronous clear and load, wrap or saturate mode, and a terminal-count pulse. Game timers, mole-slot sequencers and score/round counters use it, alongside the existing fixed-width counters.

Parameters:
WIDTH, 6, counter register width in bits
MAX_COUNT, 59, largest legal count value; the range is 0..MAX_COUNT; requires MAX_COUNT <= 2^WIDTH-1
STEP, 1, increment/decrement per enabled cycle; requires 1 <= STEP <= MAX_COUNT
SATURATE, 0, boundary mode: 0 = wrap modulo (MAX_COUNT+1), 1 = clamp at limit and hold

Ports:
clock  input  1  single rising-edge clock
reset  input  1  asynchronous, active-low reset
ena  input  1  count enable; ignored when clr or load is high
clr  input  1  synchronous clear to 0
load  input  1  synchronous load of load_value
load_value  input  WIDTH  value for load
up_down  input  1  1 = count up, 0 = count down; sampled per enabled cycle
count  output  WIDTH  registered count value
tc  output  1  registered terminal-count pulse
at_max  output  1  combinational, count == MAX_COUNT
at_zero  output  1  combinational, count == 0

Behaviour:
- Reset:
  - reset low forces count = 0 and tc = 0 immediately, with no clock edge required.
  - Held low, all inputs are ignored.
  - Deassertion is recognised at the first rising edge with reset high.
  - Reset mid-count discards the current value.
- Per-edge priority (reset high): clr > load > ena > hold.
- clr:
  - count <= 0; tc <= 0.
- load:
  - count <= min(load_value, MAX_COUNT); tc <= 0.
  - An out-of-range load clamps to MAX_COUNT.
  - load never produces tc.
- ena, up (up_down = 1):
  - Compute s = count + STEP at WIDTH+1 bits, so there is no intermediate truncation.
  - If s <= MAX_COUNT: count <= s.
  - Else, SATURATE=0: count <= s - (MAX_COUNT+1).
  - Else, SATURATE=1: count <= MAX_COUNT.
- ena, down (up_down = 0):
  - If count >= STEP: count <= count - STEP.
  - Else, SATURATE=0: count <= count + (MAX_COUNT+1) - STEP.
  - Else, SATURATE=1: count <= 0.
- Hold: ena low with no clr/load: count unchanged; tc <= 0.
- tc:
  - SATURATE=0: tc <= 1 on an enabled edge where the wrap branch was taken, else 0.
  - SATURATE=1: tc <= 1 on an enabled edge where count != limit and next count == limit (limit = MAX_COUNT up, 0 down), else 0.
  - Holding at the limit with ena high gives no further pulses.
  - tc is high for exactly the cycle in which the new count is visible.
  - Consecutive wraps (e.g. STEP large, MAX small) give back-to-back tc cycles.
- Direction change:
  - up_down may change every cycle; each enabled edge uses the value sampled at that edge.
  - SATURATE=1 at a limit, reversing direction leaves the limit normally.
- Latency:
  - count and tc update one edge after the qualifying inputs.
  - at_max/at_zero follow count combinationally with zero cycles of latency.
- Invariant: count never exceeds MAX_COUNT, given the parameter constraints.
- Arithmetic uses adders at WIDTH+1 bits; no state beyond the count and tc registers.

Test Plan:
1. Defaults; count at 17, reset pulled low between edges -> count = 0 and tc = 0 before the next edge; after release with ena=1, up -> 1.
2. Defaults; load 58, then ena=1, up_down=1 for 2 edges -> count 59 (at_max=1, tc=0), then 0 (tc=1, at_zero=1); third edge -> 1, tc=0.
3. Defaults; count 0, ena=1, up_down=0 -> count 59, tc=1; next edge -> 58, tc=0.
4. SATURATE=1; load 57, ena up for 5 edges -> 58, 59, 59, 59, 59; tc high only for the cycle count first shows 59; then down 1 edge -> 58, tc=0.
5. Defaults; load_value=62 with load=1 -> count 59; load=1 and clr=1 together -> count 0; ena=0 for 4 edges -> count holds and tc stays 0.
6. STEP=7; count 55 up -> 2, tc=1; count 3 down -> 56, tc=1; count 10 down -> 3, tc=0.

Source files
------------

// File: rtl/param_mod_counter.sv
// Parametrised modulo up/down counter with wrap or saturate boundaries,
// synchronous clear/load and a registered terminal-count pulse.
module param_mod_counter #(
  parameter int WIDTH     = 6,
  parameter int MAX_COUNT = 59,
  parameter int STEP      = 1,
  parameter bit SATURATE  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ena,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  // Wrap offsets are applied modulo 2^WIDTH; the true result always fits WIDTH bits.
  localparam logic [WIDTH-1:0] MOD_W    = WIDTH'(MAX_COUNT + 1);
  localparam logic [WIDTH-1:0] WRAP_DN_W = WIDTH'(MAX_COUNT + 1 - STEP);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;

  logic [WIDTH:0]   w_cnt_ext;
  logic [WIDTH:0]   w_up_sum;
  logic             w_up_over;
  logic             w_dn_under;
  logic [WIDTH-1:0] w_up_next;
  logic [WIDTH-1:0] w_dn_next;
  logic             w_up_tc;
  logic             w_dn_tc;
  logic [WIDTH-1:0] w_next;
  logic             w_tc_next;

  assign w_cnt_ext  = {1'b0, r_count};
  assign w_up_sum   = w_cnt_ext + STEP_EXT;
  assign w_up_over  = (w_up_sum > MAX_EXT);
  assign w_dn_under = (w_cnt_ext < STEP_EXT);

  generate
    if (SATURATE) begin : g_sat
      assign w_up_next = w_up_over ? MAX_W : w_up_sum[WIDTH-1:0];
      assign w_dn_next = w_dn_under ? '0 : (r_count - STEP_W);
      // Pulse only on arrival at the limit, not while parked there.
      assign w_up_tc   = (r_count != MAX_W) && (w_up_next == MAX_W);
      assign w_dn_tc   = (r_count != '0) && (w_dn_next == '0);
    end else begin : g_wrap
      assign w_up_next = w_up_over ? (w_up_sum[WIDTH-1:0] - MOD_W) : w_up_sum[WIDTH-1:0];
      assign w_dn_next = w_dn_under ? (r_count + WRAP_DN_W) : (r_count - STEP_W);
      assign w_up_tc   = w_up_over;
      assign w_dn_tc   = w_dn_under;
    end
  endgenerate

  always_comb begin
    w_next    = r_count;
    w_tc_next = 1'b0;
    if (clr) begin
      w_next = '0;
    end else if (load) begin
      w_next = (load_value > MAX_W) ? MAX_W : load_value;
    end else if (ena) begin
      if (up_down) begin
        w_next    = w_up_next;
        w_tc_next = w_up_tc;
      end else begin
        w_next    = w_dn_next;
        w_tc_next = w_dn_tc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_next;
      r_tc    <= w_tc_next;
    end
  end

  assign count   = r_count;
  assign tc      = r_tc;
  assign at_max  = (r_count == MAX_W);
  assign at_zero = (r_count == '0);

endmodule

// File: tb/tb_param_mod_counter.sv
// Bench for param_mod_counter: three instances (wrap/STEP=1, saturate, STEP=7)
// share stimulus and are checked against an arithmetic reference model.
module tb_param_mod_counter;

  localparam int MAXC = 59;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [5:0] load_value = '0;
  logic       up_down = 1'b0;

  logic [5:0] d_cnt [3];
  logic       d_tc [3];
  logic       d_max [3];
  logic       d_zero [3];

  int P_STEP [3] = '{1, 1, 7};
  int P_SAT [3]  = '{0, 1, 0};
  int m_cnt [3];
  bit m_tc [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  param_mod_counter u_def (
    .clock(clock), .reset(reset), .ena(ena), .clr(clr), .load(load),
    .load_value(load_value), .up_down(up_down),
    .count(d_cnt[0]), .tc(d_tc[0]), .at_max(d_max[0]), .at_zero(d_zero[0])
  );

  param_mod_counter #(.SATURATE(1'b1)) u_sat (
    .clock(clock), .reset(reset), .ena(ena), .clr(clr), .load(load),
    .load_value(load_value), .up_down(up_down),
    .count(d_cnt[1]), .tc(d_tc[1]), .at_max(d_max[1]), .at_zero(d_zero[1])
  );

  param_mod_counter #(.STEP(7)) u_step (
    .clock(clock), .reset(reset), .ena(ena), .clr(clr), .load(load),
    .load_value(load_value), .up_down(up_down),
    .count(d_cnt[2]), .tc(d_tc[2]), .at_max(d_max[2]), .at_zero(d_zero[2])
  );

  // Reference: plain modular / clamped arithmetic on integers.
  task automatic model_edge(input int k);
    int c, s, n;
    bit t;
    c = m_cnt[k];
    n = c;
    t = 1'b0;
    if (clr) begin
      n = 0;
    end else if (load) begin
      n = (int'(load_value) > MAXC) ? MAXC : int'(load_value);
    end else if (ena) begin
      if (up_down) begin
        s = c + P_STEP[k];
        if (P_SAT[k] != 0) begin
          n = (s > MAXC) ? MAXC : s;
          t = (c != MAXC) && (n == MAXC);
        end else begin
          n = s % (MAXC + 1);
          t = (s > MAXC);
        end
      end else begin
        s = c - P_STEP[k];
        if (P_SAT[k] != 0) begin
          n = (s < 0) ? 0 : s;
          t = (c != 0) && (n == 0);
        end else begin
          n = (s + MAXC + 1) % (MAXC + 1);
          t = (s < 0);
        end
      end
    end
    m_cnt[k] = n;
    m_tc[k]  = t;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0;
      m_tc[k]  = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      for (int k = 0; k < 3; k++) model_edge(k);
    end else begin
      model_reset();
    end
    @(negedge clock);
    $display("[TB] t=%0t rst_n=%b ena=%b clr=%b load=%b lv=%0d up=%b | cnt=%0d/%0d/%0d tc=%b/%b/%b",
             $time, reset, ena, clr, load, load_value, up_down,
             d_cnt[0], d_cnt[1], d_cnt[2], d_tc[0], d_tc[1], d_tc[2]);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (d_cnt[k] !== 6'd0) begin n_fail++; $display("FAIL reset_cnt[%0d]: got %0d expected 0", k, d_cnt[k]); end
      n_tests++;
      if (d_tc[k] !== 1'b0) begin n_fail++; $display("FAIL reset_tc[%0d]: got %b expected 0", k, d_tc[k]); end
    end
    @(negedge clock);
    load = 1'b1; load_value = 6'd33; ena = 1'b1; up_down = 1'b1;
    tick();
    n_tests++;
    if (d_cnt[0] !== 6'd0) begin n_fail++; $display("FAIL reset_ignores_inputs: got %0d expected 0", d_cnt[0]); end
    reset = 1'b1; ena = 1'b0; load_value = 6'd17;
    tick();
    n_tests++;
    if (d_cnt[0] !== 6'd17) begin n_fail++; $display("FAIL reset_preload17: got %0d expected 17", d_cnt[0]); end
    load = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (d_cnt[k] !== 6'd0) begin n_fail++; $display("FAIL async_reset_cnt[%0d]: got %0d expected 0", k, d_cnt[k]); end
      n_tests++;
      if (d_tc[k] !== 1'b0) begin n_fail++; $display("FAIL async_reset_tc[%0d]: got %b expected 0", k, d_tc[k]); end
    end
    #1 reset = 1'b1;
    ena = 1'b1; up_down = 1'b1;
    tick();
    n_tests++;
    if (d_cnt[0] !== 6'd1) begin n_fail++; $display("FAIL reset_release_up: got %0d expected 1", d_cnt[0]); end
    n_tests++;
    if (d_cnt[2] !== 6'd7) begin n_fail++; $display("FAIL reset_release_step7: got %0d expected 7", d_cnt[2]); end
    ena = 1'b0;
  endtask

  task automatic test_wrap_up();
    load = 1'b1; load_value = 6'd58;
    tick();
    load = 1'b0; ena = 1'b1; up_down = 1'b1;
    tick();
    n_tests++;
    if (d_cnt[0] !== 6'd59) begin n_fail++; $display("FAIL wrap_up_59: got %0d expected 59", d_cnt[0]); end
    n_tests++;
    if (d_max[0] !== 1'b1 || d_tc[0] !== 1'b0) begin n_fail++; $display("FAIL wrap_up_59_flags: got max=%b tc=%b expected max=1 tc=0", d_max[0], d_tc[0]); end
    tick();
    n_tests++;
    if (d_cnt[0] !== 6'd0) begin n_fail++; $display("FAIL wrap_up_0: got %0d expected 0", d_cnt[0]); end
    n_tests++;
    if (d_tc[0] !== 1'b1 || d_zero[0] !== 1'b1) begin n_fail++; $display("FAIL wrap_up_0_flags: got tc=%b zero=%b expected tc=1 zero=1", d_tc[0], d_zero[0]); end
    tick();
    n_tests++;
    if (d_cnt[0] !== 6'd1 || d_tc[0] !== 1'b0) begin n_fail++; $display("FAIL wrap_up_1: got cnt=%0d tc=%b expected cnt=1 tc=0", d_cnt[0], d_tc[0]); end
    ena = 1'b0;
  endtask

  task automatic test_wrap_down();
    clr = 1'b1;
    tick();
    clr = 1'b0; ena = 1'b1; up_down = 1'b0;
    tick();
    n_tests++;
    if (d_cnt[0] !== 6'd59 || d_tc[0] !== 1'b1) begin n_fail++; $display("FAIL wrap_down_59: got cnt=%0d tc=%b expected cnt=59 tc=1", d_cnt[0], d_tc[0]); end
    tick();
    n_tests++;
    if (d_cnt[0] !== 6'd58 || d_tc[0] !== 1'b0) begin n_fail++; $display("FAIL wrap_down_58: got cnt=%0d tc=%b expected cnt=58 tc=0", d_cnt[0], d_tc[0]); end
    ena = 1'b0;
  endtask

  task automatic test_saturate();
    int exp_cnt [5] = '{58, 59, 59, 59, 59};
    bit exp_tc [5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    load = 1'b1; load_value = 6'd57;
    tick();
    load = 1'b0; ena = 1'b1; up_down = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (d_cnt[1] !== 6'(exp_cnt[i]) || d_tc[1] !== exp_tc[i]) begin
        n_fail++;
        $display("FAIL sat_up[%0d]: got cnt=%0d tc=%b expected cnt=%0d tc=%b", i, d_cnt[1], d_tc[1], exp_cnt[i], exp_tc[i]);
      end
    end
    up_down = 1'b0;
    tick();
    n_tests++;
    if (d_cnt[1] !== 6'd58 || d_tc[1] !== 1'b0) begin n_fail++; $display("FAIL sat_leave_max: got cnt=%0d tc=%b expected cnt=58 tc=0", d_cnt[1], d_tc[1]); end
    ena = 1'b0;
  endtask

  task automatic test_load_clr();
    load = 1'b1; load_value = 6'd62;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (d_cnt[k] !== 6'd59) begin n_fail++; $display("FAIL load_clamp[%0d]: got %0d expected 59", k, d_cnt[k]); end
    end
    clr = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (d_cnt[k] !== 6'd0) begin n_fail++; $display("FAIL clr_over_load[%0d]: got %0d expected 0", k, d_cnt[k]); end
    end
    clr = 1'b0; load = 1'b0; ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up_down = ~up_down;
      tick();
      n_tests++;
      if (d_cnt[0] !== 6'd0 || d_tc[0] !== 1'b0) begin n_fail++; $display("FAIL hold[%0d]: got cnt=%0d tc=%b expected cnt=0 tc=0", i, d_cnt[0], d_tc[0]); end
    end
  endtask

  task automatic test_step();
    load = 1'b1; load_value = 6'd55;
    tick();
    load = 1'b0; ena = 1'b1; up_down = 1'b1;
    tick();
    n_tests++;
    if (d_cnt[2] !== 6'd2 || d_tc[2] !== 1'b1) begin n_fail++; $display("FAIL step_up_wrap: got cnt=%0d tc=%b expected cnt=2 tc=1", d_cnt[2], d_tc[2]); end
    load = 1'b1; load_value = 6'd3;
    tick();
    load = 1'b0; up_down = 1'b0;
    tick();
    n_tests++;
    if (d_cnt[2] !== 6'd56 || d_tc[2] !== 1'b1) begin n_fail++; $display("FAIL step_down_wrap: got cnt=%0d tc=%b expected cnt=56 tc=1", d_cnt[2], d_tc[2]); end
    load = 1'b1; load_value = 6'd10;
    tick();
    load = 1'b0;
    tick();
    n_tests++;
    if (d_cnt[2] !== 6'd3 || d_tc[2] !== 1'b0) begin n_fail++; $display("FAIL step_down_plain: got cnt=%0d tc=%b expected cnt=3 tc=0", d_cnt[2], d_tc[2]); end
    ena = 1'b0;
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      r          = int'($urandom_range(0, 99));
      clr        = (r < 4);
      load       = (r >= 4 && r < 12);
      ena        = ($urandom_range(0, 3) != 0);
      up_down    = 1'($urandom_range(0, 1));
      load_value = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (d_cnt[0] !== 6'd0 || d_cnt[2] !== 6'd0) begin n_fail++; $display("FAIL rand_async_reset i=%0d: got %0d/%0d expected 0/0", i, d_cnt[0], d_cnt[2]); end
        #1 reset = 1'b1;
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (d_cnt[k] !== 6'(m_cnt[k])) begin n_fail++; $display("FAIL rand_cnt[%0d] i=%0d: got %0d expected %0d", k, i, d_cnt[k], m_cnt[k]); end
        n_tests++;
        if (d_tc[k] !== m_tc[k]) begin n_fail++; $display("FAIL rand_tc[%0d] i=%0d: got %b expected %b", k, i, d_tc[k], m_tc[k]); end
        n_tests++;
        if (d_max[k] !== (m_cnt[k] == MAXC) || d_zero[k] !== (m_cnt[k] == 0)) begin
          n_fail++;
          $display("FAIL rand_flags[%0d] i=%0d: got max=%b zero=%b for expected count %0d", k, i, d_max[k], d_zero[k], m_cnt[k]);
        end
      end
    end
    clr = 1'b0; load = 1'b0; ena = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load_clr();
    test_step();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
